jtpopeye_colmix: RTL and testbench

- Final video stage downstream of the background layer.
- Takes the 5-bit background colour (BAKC), the object pixel and the text pixel each pixel clock, and resolves priority between them.
- Looks the winner up in a downloadable 64x8 palette and expands it to 4-bit RGB with delayed blanking.
- Also holds the CPU-written palette-bank latch that selects the background palette half.

---
 rtl/jtpopeye_pkg.sv | 40 ++++
 rtl/jtpopeye_pal_ram.sv | 30 +++
 rtl/jtpopeye_colmix.sv | 115 +++++++++++
 tb/tb_jtpopeye_colmix.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/jtpopeye_pkg.sv
// Shared constants for the Popeye colour mixer: priority index bases,
// palette byte layout and the default blanking delay.
package jtpopeye_pkg;

  localparam int BLANK_DLY_DEF = 3;

  // Palette index bases for the three layers (6-bit index space)
  localparam logic [5:0] TXT_BASE = 6'h30;
  localparam logic [5:0] OBJ_BASE = 6'h20;
  localparam logic [5:0] BG_BASE  = 6'h00;

  // Palette byte layout: RRRGGGBB
  localparam int R_HI = 7;
  localparam int R_LO = 5;
  localparam int G_HI = 4;
  localparam int G_LO = 2;
  localparam int B_HI = 1;
  localparam int B_LO = 0;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  // Text/object indices (bit 5 set) land in the upper half of the 128-entry RAM
  function automatic logic [6:0] pal_addr(input logic [5:0] idx);
    return {idx[5], idx};
  endfunction

  // Expand a palette byte to 4 bits per gun by replicating the top bits
  function automatic rgb_t expand(input logic [7:0] pal);
    rgb_t c;
    c.r = {pal[R_HI:R_LO], pal[R_HI]};
    c.g = {pal[G_HI:G_LO], pal[G_HI]};
    c.b = {pal[B_HI:B_LO], pal[B_HI:B_LO]};
    return c;
  endfunction

endpackage

// File: rtl/jtpopeye_pal_ram.sv
// Single write port, synchronous read RAM with read enable; the read
// register clears on reset, the array contents do not.
module jtpopeye_pal_ram #(
  parameter int AW = 7,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  // Write port: contents are not reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read; a same-cycle write to the same address returns old data
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/jtpopeye_colmix.sv
// Popeye colour mixer: layer priority, palette lookup and RGB expansion
// in a three-stage pixel-enable pipeline with matching blank delay.
module jtpopeye_colmix
  import jtpopeye_pkg::*;
#(
  parameter int BLANK_DLY = BLANK_DLY_DEF,
  parameter int PAL_AW    = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pxl_cen,
  input  logic              cpu_cen,
  input  logic              CSPAL_n,
  input  logic [7:0]        DD,
  input  logic [4:0]        BAKC,
  input  logic [4:0]        OBJC,
  input  logic [3:0]        TXTC,
  input  logic              LHBL,
  input  logic              LVBL,
  input  logic [PAL_AW-1:0] prog_addr,
  input  logic [7:0]        prog_data,
  input  logic              prog_we,
  input  logic              downloading,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              LHBL_dly,
  output logic              LVBL_dly
);

  logic                 bank;
  logic [5:0]           idx_next;
  logic [5:0]           idx;
  logic                 dl_s1;
  logic                 dl_s2;
  logic [BLANK_DLY-1:0] lh_sr;
  logic [BLANK_DLY-1:0] lv_sr;
  logic [7:0]           pal_q;
  logic                 kill;
  rgb_t                 col;

  // BAKC[0] and DD[7:1] carry no meaning for this block
  logic unused_bits;
  assign unused_bits = ^{BAKC[0], DD[7:1]};

  // CPU palette-bank latch, independent of the pixel enable
  always_ff @(posedge clk) begin
    if (rst)                      bank <= 1'b0;
    else if (cpu_cen && !CSPAL_n) bank <= DD[0];
  end

  // Priority: opaque text beats opaque object beats background
  always_comb begin
    idx_next = BG_BASE | {1'b0, bank, BAKC[4:1]};
    if (TXTC[1:0] != 2'd0)      idx_next = TXT_BASE | {2'b00, TXTC};
    else if (OBJC[1:0] != 2'd0) idx_next = OBJ_BASE | {1'b0, OBJC};
  end

  // Stage 1 index register plus download marker carried alongside the pixel
  always_ff @(posedge clk) begin
    if (rst) begin
      idx   <= '0;
      dl_s1 <= 1'b0;
      dl_s2 <= 1'b0;
    end else if (pxl_cen) begin
      idx   <= idx_next;
      dl_s1 <= downloading;
      dl_s2 <= dl_s1 | downloading;
    end
  end

  // Blanking shift registers, advanced with the pixel pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      lh_sr <= '0;
      lv_sr <= '0;
    end else if (pxl_cen) begin
      lh_sr <= {lh_sr[BLANK_DLY-2:0], LHBL};
      lv_sr <= {lv_sr[BLANK_DLY-2:0], LVBL};
    end
  end

  assign LHBL_dly = lh_sr[BLANK_DLY-1];
  assign LVBL_dly = lv_sr[BLANK_DLY-1];

  // Stage 2: palette lookup
  jtpopeye_pal_ram #(.AW(PAL_AW), .DW(8)) u_pal (
    .clk   (clk),
    .rst   (rst),
    .we    (prog_we & downloading),
    .waddr (prog_addr),
    .wdata (prog_data),
    .re    (pxl_cen),
    .raddr (pal_addr(idx)),
    .rdata (pal_q)
  );

  // Pixel is dark if blanked or if a download touched any stage it passed
  assign kill = ~lh_sr[BLANK_DLY-2] | ~lv_sr[BLANK_DLY-2] | dl_s2 | downloading;
  assign col  = expand(pal_q);

  // Stage 3: colour expansion and blanking
  always_ff @(posedge clk) begin
    if (rst) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else if (pxl_cen) begin
      red   <= kill ? 4'd0 : col.r;
      green <= kill ? 4'd0 : col.g;
      blue  <= kill ? 4'd0 : col.b;
    end
  end

endmodule

// File: tb/tb_jtpopeye_colmix.sv
// Randomised and directed bench for jtpopeye_colmix against a pixel-level model.
module tb_jtpopeye_colmix;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pxl_cen = 1'b0, cpu_cen = 1'b0, CSPAL_n = 1'b1;
  logic [7:0] DD = '0;
  logic [4:0] BAKC = '0, OBJC = '0;
  logic [3:0] TXTC = '0;
  logic       LHBL = 1'b0, LVBL = 1'b0;
  logic [6:0] prog_addr = '0;
  logic [7:0] prog_data = '0;
  logic       prog_we = 1'b0, downloading = 1'b0;
  logic [3:0] red, green, blue;
  logic       LHBL_dly, LVBL_dly;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  jtpopeye_colmix dut (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .cpu_cen(cpu_cen), .CSPAL_n(CSPAL_n),
    .DD(DD), .BAKC(BAKC), .OBJC(OBJC), .TXTC(TXTC), .LHBL(LHBL), .LVBL(LVBL),
    .prog_addr(prog_addr), .prog_data(prog_data), .prog_we(prog_we),
    .downloading(downloading), .red(red), .green(green), .blue(blue),
    .LHBL_dly(LHBL_dly), .LVBL_dly(LVBL_dly)
  );

  task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: one record per pixel ----------------
  typedef struct {
    int  idx;
    bit  lh, lv, dl;
    int  data;
  } pix_t;

  int   pal_m [128];
  bit   bank_m;
  pix_t q1, q2, cur;
  int   exp_r, exp_g, exp_b;
  bit   exp_lh, exp_lv;
  int   r3, g3, b2, a;

  initial for (int i = 0; i < 128; i++) pal_m[i] = 0;

  always @(posedge clk) begin
    if (rst) begin
      bank_m = 0;
      q1 = '{0, 0, 0, 0, 0};
      q2 = '{0, 0, 0, 0, 0};
      exp_r = 0; exp_g = 0; exp_b = 0; exp_lh = 0; exp_lv = 0;
    end else begin
      if (pxl_cen) begin
        if (TXTC % 4 != 0)      cur.idx = 48 + TXTC;
        else if (OBJC % 4 != 0) cur.idx = 32 + OBJC;
        else                    cur.idx = bank_m * 16 + BAKC / 2;
        cur.lh = LHBL; cur.lv = LVBL; cur.dl = downloading; cur.data = 0;
        // pixel from two enables ago reaches the output now
        if (!q2.lh || !q2.lv || q2.dl || q1.dl || cur.dl) begin
          exp_r = 0; exp_g = 0; exp_b = 0;
        end else begin
          r3 = q2.data / 32; g3 = (q2.data / 4) % 8; b2 = q2.data % 4;
          exp_r = r3 * 2 + r3 / 4;
          exp_g = g3 * 2 + g3 / 4;
          exp_b = b2 * 4 + b2;
        end
        exp_lh = q2.lh; exp_lv = q2.lv;
        // palette read happens before this edge's write lands
        a = q1.idx + ((q1.idx >= 32) ? 64 : 0);
        q1.data = pal_m[a];
        q2 = q1; q1 = cur;
      end
      if (cpu_cen && !CSPAL_n) bank_m = DD[0];
      if (prog_we && downloading) pal_m[prog_addr] = prog_data;
    end
  end

  // Compare outputs against the model on every cycle
  always @(negedge clk) begin
    chk("rgb", {red, green, blue}, {exp_r[3:0], exp_g[3:0], exp_b[3:0]});
    chk("blank_dly", {10'd0, LHBL_dly, LVBL_dly}, {10'd0, exp_lh, exp_lv});
  end

  // One pixel enable followed by one idle cycle; returns on a falling edge
  task automatic pix(input logic [4:0] bk, input logic [4:0] ob, input logic [3:0] tx,
                     input logic lh, input logic bw, input logic dl);
    BAKC = bk; OBJC = ob; TXTC = tx; LHBL = lh; LVBL = 1'b1;
    cpu_cen = bw; CSPAL_n = ~bw; DD = 8'h01; downloading = dl; prog_we = dl;
    pxl_cen = 1'b1;
    @(negedge clk);
    pxl_cen = 1'b0; cpu_cen = 1'b0; CSPAL_n = 1'b1; prog_we = 1'b0;
    @(negedge clk);
    $display("pix bakc=%h objc=%h txtc=%h lh=%0d dl=%0d -> rgb=%h%h%h lhd=%0d",
             bk, ob, tx, lh, dl, red, green, blue, LHBL_dly);
  endtask

  initial begin
    // reset with busy inputs
    pxl_cen = 1'b1; LHBL = 1'b1; LVBL = 1'b1; BAKC = 5'h0A; TXTC = 4'h5;
    cpu_cen = 1'b1; CSPAL_n = 1'b0; DD = 8'h01;
    repeat (4) @(negedge clk);
    chk("reset_rgb", {red, green, blue}, 12'h000);
    chk("reset_blank", {10'd0, LHBL_dly, LVBL_dly}, 12'h000);
    rst = 1'b0; pxl_cen = 1'b0; cpu_cen = 1'b0; CSPAL_n = 1'b1; TXTC = 4'h0;

    // full palette download, pixels keep flowing
    downloading = 1'b1;
    for (int i = 0; i < 128; i++) begin
      prog_addr = 7'(i);
      case (i)
        5:       prog_data = 8'hE3;
        8'h75:   prog_data = 8'hA9;
        8'h67:   prog_data = 8'h5E;
        8'h15:   prog_data = 8'h1C;
        default: prog_data = 8'($urandom);
      endcase
      prog_we = 1'b1; pxl_cen = i[0];
      @(negedge clk);
    end
    prog_we = 1'b0; pxl_cen = 1'b0; downloading = 1'b0;
    @(negedge clk);

    repeat (3) pix(5'h0A, 5'h00, 4'h0, 1, 0, 0);
    chk("bg_pixel", {red, green, blue}, 12'hF0F);
    repeat (3) pix(5'h1F, 5'h07, 4'h5, 1, 0, 0);
    chk("txt_prio", {red, green, blue}, 12'hB45);
    repeat (3) pix(5'h1F, 5'h07, 4'h4, 1, 0, 0);
    chk("obj_prio", {red, green, blue}, 12'h4FA);

    // bank write coincident with a pixel: that pixel still uses bank 0
    pix(5'h0A, 5'h00, 4'h0, 1, 1, 0);
    repeat (2) pix(5'h0A, 5'h00, 4'h0, 1, 0, 0);
    chk("bank_old", {red, green, blue}, 12'hF0F);
    pix(5'h0A, 5'h00, 4'h0, 1, 0, 0);
    chk("bank_new", {red, green, blue}, 12'h0F0);

    // one blanked pixel
    pix(5'h0A, 5'h00, 4'h0, 0, 0, 0);
    pix(5'h0A, 5'h00, 4'h0, 1, 0, 0);
    chk("blank_before", {11'd0, LHBL_dly}, 12'h001);
    pix(5'h0A, 5'h00, 4'h0, 1, 0, 0);
    chk("blank_hit", {LHBL_dly, red, green, blue[2:0]}, 12'h000);
    pix(5'h0A, 5'h00, 4'h0, 1, 0, 0);
    chk("blank_after", {red, green, blue}, 12'h0F0);
    chk("blank_after_lh", {11'd0, LHBL_dly}, 12'h001);

    // download override mid-frame
    prog_addr = 7'h40; prog_data = 8'hFF;
    pix(5'h0A, 5'h00, 4'h0, 1, 0, 1);
    chk("dl_force", {red, green, blue}, 12'h000);
    pix(5'h0A, 5'h00, 4'h0, 1, 0, 1);
    pix(5'h0A, 5'h00, 4'h0, 1, 0, 0);
    chk("dl_rel1", {red, green, blue}, 12'h000);
    pix(5'h0A, 5'h00, 4'h0, 1, 0, 0);
    chk("dl_rel2", {red, green, blue}, 12'h000);
    pix(5'h0A, 5'h00, 4'h0, 1, 0, 0);
    chk("dl_rel3", {red, green, blue}, 12'h0F0);

    // randomised traffic
    for (int i = 0; i < 4000; i++) begin
      pxl_cen   = ($urandom % 3) == 0;
      cpu_cen   = $urandom % 2;
      CSPAL_n   = ($urandom % 8) != 0;
      DD        = 8'($urandom);
      BAKC      = 5'($urandom);
      OBJC      = 5'($urandom);
      TXTC      = 4'($urandom);
      LHBL      = ($urandom % 16) != 0;
      LVBL      = ($urandom % 32) != 0;
      downloading = (i % 500) >= 470;
      prog_we   = $urandom % 2;
      prog_addr = 7'($urandom);
      prog_data = 8'($urandom);
      @(negedge clk);
      if (pxl_cen && (i % 400) == 0)
        $display("rand %0d rgb=%h%h%h lhd=%0d lvd=%0d", i, red, green, blue, LHBL_dly, LVBL_dly);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
